// File: rtl/hv_memory_server.sv
// Per-modality responder for the spatial encoder: bulk-loads the iM / projM_neg / projM_pos rows
// through a narrow word stream, then serves full hypervector rows with a one-cycle read latency.
module hv_memory_server #(
  parameter int HV_DIMENSION = 2000,
  parameter int DEPTH        = 214,
  parameter int ADDR_WIDTH   = 8,
  parameter int LOAD_WIDTH   = 40
) (
  input  logic                  Clk_CI,
  input  logic                  Reset_RI,
  input  logic                  Req_SI,
  input  logic [ADDR_WIDTH-1:0] Addr_DI,
  output logic                  Ready_SO,
  output logic                  Valid_SO,
  output logic [0:HV_DIMENSION-1] IMOut_DO,
  output logic [0:HV_DIMENSION-1] ProjNeg_DO,
  output logic [0:HV_DIMENSION-1] ProjPos_DO,
  input  logic                  Reload_SI,
  input  logic                  LoadValid_SI,
  output logic                  LoadReady_SO,
  input  logic [LOAD_WIDTH-1:0] LoadData_DI,
  output logic                  LoadDone_SO
);

  localparam int WORDS  = HV_DIMENSION / LOAD_WIDTH;
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int ROW_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_LOAD, ST_SERVE} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            bank_cnt_reg;
  logic [ROW_W-1:0]      row_cnt_reg;
  logic [WORD_W-1:0]     word_cnt_reg;
  logic                  load_done_reg;
  logic                  req_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  load_accept;
  logic                  word_last, row_last, bank_last, final_word;
  logic                  rd_en;
  logic                  addr_in_range;

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) state_reg <= ST_LOAD;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_LOAD:  if (final_word) state_next = ST_SERVE;
      ST_SERVE: if (Reload_SI)  state_next = ST_LOAD;
      default:  state_next = ST_LOAD;
    endcase
  end

  always_comb begin
    Ready_SO     = 1'b0;
    LoadReady_SO = 1'b0;
    case (state_reg)
      ST_LOAD:  LoadReady_SO = 1'b1;
      ST_SERVE: Ready_SO     = 1'b1;
      default:  LoadReady_SO = 1'b1;
    endcase
  end

  assign load_accept = LoadValid_SI & LoadReady_SO;
  assign word_last   = (word_cnt_reg == WORD_W'(WORDS - 1));
  assign row_last    = (row_cnt_reg == ROW_W'(DEPTH - 1));
  assign bank_last   = (bank_cnt_reg == 2'd2);
  assign final_word  = load_accept & word_last & row_last & bank_last;

  // Load counters wrap word -> row -> bank; the final wrap leaves them all at zero for the next load.
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      bank_cnt_reg <= '0;
      row_cnt_reg  <= '0;
      word_cnt_reg <= '0;
    end else if (load_accept) begin
      if (word_last) begin
        word_cnt_reg <= '0;
        if (row_last) begin
          row_cnt_reg  <= '0;
          bank_cnt_reg <= bank_last ? 2'd0 : bank_cnt_reg + 2'd1;
        end else begin
          row_cnt_reg <= row_cnt_reg + ROW_W'(1);
        end
      end else begin
        word_cnt_reg <= word_cnt_reg + WORD_W'(1);
      end
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) load_done_reg <= 1'b0;
    else          load_done_reg <= final_word;
  end

  // Reload takes priority over a simultaneous request: no read is issued and the request is dropped.
  assign rd_en         = (state_reg == ST_SERVE) & Req_SI & ~Reload_SI;
  assign addr_in_range = (32'(Addr_DI) < DEPTH);

  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      req_reg  <= 1'b0;
      addr_reg <= '0;
    end else begin
      req_reg <= rd_en;
      if (rd_en) addr_reg <= Addr_DI;
    end
  end

  assign Valid_SO    = (state_reg == ST_SERVE) & req_reg & Req_SI & (addr_reg == Addr_DI);
  assign LoadDone_SO = load_done_reg;

  // One narrow RAM column per load word and bank, so a load word is a plain single-word write.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_col
      logic [LOAD_WIDTH-1:0] im_mem  [DEPTH];
      logic [LOAD_WIDTH-1:0] neg_mem [DEPTH];
      logic [LOAD_WIDTH-1:0] pos_mem [DEPTH];
      logic [LOAD_WIDTH-1:0] im_q_reg, neg_q_reg, pos_q_reg;
      logic                  col_we;

      assign col_we = load_accept & (word_cnt_reg == WORD_W'(gi));

      always_ff @(posedge Clk_CI) begin
        if (col_we && bank_cnt_reg == 2'd0) im_mem[row_cnt_reg]  <= LoadData_DI;
        if (col_we && bank_cnt_reg == 2'd1) neg_mem[row_cnt_reg] <= LoadData_DI;
        if (col_we && bank_cnt_reg == 2'd2) pos_mem[row_cnt_reg] <= LoadData_DI;
      end

      always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
          im_q_reg  <= '0;
          neg_q_reg <= '0;
          pos_q_reg <= '0;
        end else if (rd_en) begin
          im_q_reg  <= addr_in_range ? im_mem[Addr_DI[ROW_W-1:0]]  : '0;
          neg_q_reg <= addr_in_range ? neg_mem[Addr_DI[ROW_W-1:0]] : '0;
          pos_q_reg <= addr_in_range ? pos_mem[Addr_DI[ROW_W-1:0]] : '0;
        end
      end

      assign IMOut_DO[gi*LOAD_WIDTH +: LOAD_WIDTH]   = im_q_reg;
      assign ProjNeg_DO[gi*LOAD_WIDTH +: LOAD_WIDTH] = neg_q_reg;
      assign ProjPos_DO[gi*LOAD_WIDTH +: LOAD_WIDTH] = pos_q_reg;
    end
  endgenerate

endmodule

// File: tb/tb_hv_memory_server.sv
// Directed bench for hv_memory_server: loads rows from a reference model, then checks served rows
// and the ready/valid handshake through a scoreboard of expected responses.
module tb_hv_memory_server;

  // Reduced row count keeps three full loads well inside the cycle budget; row width is unchanged.
  localparam int HV    = 2000;
  localparam int DEPTH = 40;
  localparam int AW    = 8;
  localparam int LW    = 40;
  localparam int W     = HV / LW;
  localparam int TOTAL = 3 * DEPTH * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic [AW-1:0] addr;
  logic          ready, valid;
  logic [0:HV-1] im_out, neg_out, pos_out;
  logic          reload;
  logic          load_valid, load_ready;
  logic [LW-1:0] load_data;
  logic          load_done;

  int errors = 0;
  int checks = 0;
  bit junk_load = 1'b0;

  logic [0:HV-1] m_im  [DEPTH];
  logic [0:HV-1] m_neg [DEPTH];
  logic [0:HV-1] m_pos [DEPTH];

  typedef struct {
    string         tag;
    logic          v;
    bit            rows;
    logic [0:HV-1] im, ng, ps;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  hv_memory_server #(
    .HV_DIMENSION(HV), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LOAD_WIDTH(LW)
  ) dut (
    .Clk_CI(clk), .Reset_RI(rst), .Req_SI(req), .Addr_DI(addr),
    .Ready_SO(ready), .Valid_SO(valid),
    .IMOut_DO(im_out), .ProjNeg_DO(neg_out), .ProjPos_DO(pos_out),
    .Reload_SI(reload), .LoadValid_SI(load_valid), .LoadReady_SO(load_ready),
    .LoadData_DI(load_data), .LoadDone_SO(load_done)
  );

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [0:HV-1] obs, input logic [0:HV-1] exp);
    int k;
    checks++;
    assert (obs === exp) else begin
      errors++;
      k = 0;
      while (k < W - 1 && obs[k*LW +: LW] === exp[k*LW +: LW]) k++;
      $error("FAIL %s: word %0d observed=%h expected=%h", tag, k, obs[k*LW +: LW], exp[k*LW +: LW]);
    end
  endtask

  task automatic gen_model();
    logic [63:0] t;
    for (int r = 0; r < DEPTH; r++)
      for (int k = 0; k < W; k++) begin
        t = {$urandom(), $urandom()}; m_im[r][k*LW +: LW]  = t[LW-1:0];
        t = {$urandom(), $urandom()}; m_neg[r][k*LW +: LW] = t[LW-1:0];
        t = {$urandom(), $urandom()}; m_pos[r][k*LW +: LW] = t[LW-1:0];
      end
  endtask

  function automatic logic [LW-1:0] get_word(input int b, input int r, input int k);
    case (b)
      0:       return m_im[r][k*LW +: LW];
      1:       return m_neg[r][k*LW +: LW];
      default: return m_pos[r][k*LW +: LW];
    endcase
  endfunction

  // Streams the first n_words of the model; reload_at >= 0 pulses Reload_SI alongside that word.
  task automatic do_load(input bit gaps, input int n_words, input int reload_at);
    int idx = 0;
    int cyc = 0;
    while (idx < n_words && cyc < 4 * n_words + 100) begin
      @(negedge clk);
      load_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      load_data  = get_word(idx / (DEPTH * W), (idx / W) % DEPTH, idx % W);
      reload     = (idx == reload_at);
      req        = 1'b0;
      #1;
      if (load_valid && load_ready) idx++;
      cyc++;
    end
    checks++;
    assert (idx == n_words) else begin
      errors++;
      $error("FAIL load_timeout: observed=%0d expected=%0d words", idx, n_words);
    end
    @(negedge clk);
    load_valid = 1'b0;
    reload     = 1'b0;
    #1;
    if (n_words == TOTAL) begin
      chk_bit("load_done_pulse", load_done, 1'b1);
      chk_bit("ready_at_done", ready, 1'b1);
      chk_bit("load_ready_at_done", load_ready, 1'b0);
      @(negedge clk);
      #1;
      chk_bit("load_done_single", load_done, 1'b0);
    end
  endtask

  task automatic step(input string tag, input logic rq, input int a, input logic exp_valid,
                      input bit chk_rows, input int row_addr, input bit rl);
    exp_t e;
    @(negedge clk);
    req        = rq;
    addr       = AW'(a);
    reload     = rl;
    load_valid = junk_load;
    load_data  = LW'({$urandom(), $urandom()});
    e.tag  = tag;
    e.v    = exp_valid;
    e.rows = chk_rows;
    e.im   = (row_addr < DEPTH) ? m_im[row_addr]  : '0;
    e.ng   = (row_addr < DEPTH) ? m_neg[row_addr] : '0;
    e.ps   = (row_addr < DEPTH) ? m_pos[row_addr] : '0;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    chk_bit({e.tag, "_valid"}, valid, e.v);
    if (e.rows) begin
      chk_row({e.tag, "_im"}, im_out, e.im);
      chk_row({e.tag, "_neg"}, neg_out, e.ng);
      chk_row({e.tag, "_pos"}, pos_out, e.ps);
    end
    $display("step %s req=%b addr=%0d valid=%b", tag, rq, a, valid);
  endtask

  task automatic verify_all(input string tag);
    step({tag, "_idle"}, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    for (int a = 0; a < DEPTH; a++) begin
      step($sformatf("%s_r%0d_first", tag, a), 1'b1, a, 1'b0, 1'b0, a, 1'b0);
      step($sformatf("%s_r%0d_held", tag, a), 1'b1, a, 1'b1, 1'b1, a, 1'b0);
    end
  endtask

  logic [0:HV-1] zero_row;

  initial begin
    zero_row   = '0;
    rst        = 1'b1;
    req        = 1'b0;
    addr       = '0;
    reload     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    gen_model();
    repeat (3) @(negedge clk);
    #1;
    chk_bit("rst_ready", ready, 1'b0);
    chk_bit("rst_valid", valid, 1'b0);
    chk_bit("rst_load_ready", load_ready, 1'b1);
    chk_bit("rst_load_done", load_done, 1'b0);
    chk_row("rst_im", im_out, zero_row);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back load with a Reload_SI pulse mid-load, which must be ignored.
    do_load(1'b0, TOTAL, 1234);
    junk_load = 1'b1;
    verify_all("b2b");
    junk_load = 1'b0;

    step("idle", 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    step("a5_0", 1'b1, 5, 1'b0, 1'b0, 5, 1'b0);
    step("a5_1", 1'b1, 5, 1'b1, 1'b1, 5, 1'b0);
    step("a5_2", 1'b1, 5, 1'b1, 1'b1, 5, 1'b0);
    step("a5_3", 1'b1, 5, 1'b1, 1'b1, 5, 1'b0);
    step("req_low", 1'b0, 5, 1'b0, 1'b1, 5, 1'b0);
    step("oor_0", 1'b1, 220, 1'b0, 1'b0, 220, 1'b0);
    step("oor_1", 1'b1, 220, 1'b1, 1'b1, 220, 1'b0);

    step("rl_a", 1'b1, 3, 1'b0, 1'b0, 3, 1'b0);
    step("rl_b", 1'b1, 3, 1'b1, 1'b1, 3, 1'b0);
    step("rl_pulse", 1'b1, 3, 1'b1, 1'b0, 3, 1'b1);
    step("rl_after", 1'b1, 3, 1'b0, 1'b0, 3, 1'b0);
    chk_bit("rl_ready", ready, 1'b0);
    chk_bit("rl_load_ready", load_ready, 1'b1);

    // Same contents streamed with random gaps must read back identically.
    do_load(1'b1, TOTAL, -1);
    verify_all("gap");

    // New contents: partial load, reset, then a full reload.
    step("rl2", 1'b0, 0, 1'b0, 1'b0, 0, 1'b1);
    gen_model();
    do_load(1'b0, TOTAL / 2 + 17, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_bit("midrst_load_ready", load_ready, 1'b1);
    chk_bit("midrst_ready", ready, 1'b0);
    chk_bit("midrst_load_done", load_done, 1'b0);
    do_load(1'b0, TOTAL, -1);
    verify_all("rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
